mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port main memory between two requesters: the CPU stage-3 data access and a DMA/program-loader port.
- Sits between the stage-3 pipeline registers and mem_main.
- Produces cpu_stall, which feeds the hazard/PC stall path.
- Sequences each access through a fixed-latency FSM, with CPU-priority arbitration and a starvation guard for DMA.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, cycles the memory address is held before read data is valid (>=1).
- STARVE_MAX, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- halt_sys  in  1  freeze from main control
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dma_req / dma_we / dma_addr / dma_wdata  in  1/1/AW/DW  DMA request bundle, same rules as CPU
- dma_rdata  out  DW  DMA read data
- dma_ack  out  1  DMA completion pulse
- mem_we  out  1  to mem_main write_en
- mem_addr  out  AW  to mem_main address
- mem_wdata  out  DW  to mem_main write_data
- mem_rdata  in  DW  from mem_main data_out
- owner  out  owner_t  current grant holder
- busy  out  1  FSM not in ARB_IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (rst low, takes effect immediately): state ARB_IDLE; owner OWN_NONE; busy, mem_we, cpu_ack, dma_ack = 0; mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0; starve counter 0.
- FSM states: ARB_IDLE -> ARB_ACCESS -> ARB_ACK -> ARB_IDLE.
- ARB_IDLE:
  - No request: stay.
  - Otherwise select a winner. Default is CPU. DMA wins if only dma_req is high, or if starve count == STARVE_MAX.
  - At the edge: latch winner's addr, wdata and we into mem_addr, mem_wdata and an internal we; set owner; go to ARB_ACCESS with lat_cnt = 0.
- ARB_ACCESS:
  - mem_addr and mem_wdata held stable.
  - mem_we = latched we, only in the first ACCESS cycle (lat_cnt == 0). This gives exactly one write per transaction.
  - lat_cnt increments each cycle. When lat_cnt == MEM_LAT-1, capture mem_rdata into the owner's rdata register (read transactions only; on a write the rdata register holds) and go to ARB_ACK.
- ARB_ACK:
  - Owner's ack = 1 for exactly this cycle.
  - rdata is valid and is held until that owner's next read.
  - Next state ARB_IDLE; owner returns to OWN_NONE.
- Latency: request sampled in cycle N gives ack in cycle N+1+MEM_LAT. Transaction period is 2+MEM_LAT cycles.
- Requester rules:
  - req, addr, wdata and we must be held until ack. Changes after the grant are ignored.
  - A req still high in the cycle after ack is treated as a new transaction.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each CPU grant while dma_req = 1.
  - Clears on a DMA grant, or on any cycle where dma_req = 0.
- halt_sys = 1:
  - FSM, lat_cnt and starve counter hold; no new grants; mem_we forced 0; acks suppressed.
  - An ACK-state pulse is deferred until the halt releases.
  - A write already issued is not reissued.
- Simultaneous requests with starve count < STARVE_MAX: CPU first, then DMA at the next ARB_IDLE (if dma_req is still high).
- A req deasserted before grant is dropped silently.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and requesters must reissue. An in-flight write may or may not have committed; software must not rely on it.
- The block adds no width conversion; addresses are passed unmodified (byte addressing is the memory's concern).

Decomposition:
- types_pkg gets:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_DMA}
  - arb_state_e enum {ARB_IDLE, ARB_ACCESS, ARB_ACK}
- Sub-module arb_pick: combinational winner select plus the registered starvation counter (clk/rst, cpu_req, dma_req, grant_event, halt_sys -> winner). The FSM and datapath latching stay in mem_arbiter.

Test Plan:
- MEM_LAT=1, mem[0x0010]=0xBEEF; CPU read 0x0010 asserted in cycle 0 -> cpu_stall = 1 in cycles 0-1; cpu_ack and cpu_rdata = 0xBEEF in cycle 2; owner = OWN_CPU in cycles 1-2.
- Both req in cycle 0 (dma write 0x0020 <- 0x1234, cpu read 0x0030) -> cpu_ack in cycle 2; mem_we = 1 only in cycle 4 with addr 0x0020; dma_ack in cycle 5; a following CPU read of 0x0020 returns 0x1234.
- STARVE_MAX=2, cpu_req and dma_req held high continuously -> grant order CPU, CPU, DMA, CPU, CPU, DMA; acks every 3 cycles.
- MEM_LAT=3, CPU read; halt_sys high for 3 cycles starting in the second ACCESS cycle -> ack in cycle 7 instead of 4; mem_we never pulses; mem_addr stable throughout.
- DMA write in progress; rst low in the first ACCESS cycle -> mem_we = 0, owner = OWN_NONE and busy = 0 immediately; no dma_ack; after release, a reissued request completes normally.
- CPU write, cpu_req held after ack -> second transaction starts in the cycle after ack; mem_we pulses exactly once per transaction.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: grant owner and FSM state encodings.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_ACK} arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the CPU, DMA, the arbiter and mem_main.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ack;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // The arbiter sits on the slave side of this bundle.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between CPU and DMA with a saturating starvation counter
// that forces a DMA grant after STARVE_MAX back-to-back CPU wins.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   grant_event,
    input  logic   halt_sys,
    output owner_t winner
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = (r_starve == SW'(STARVE_MAX));

    always_comb begin
        winner = OWN_NONE;
        if (dma_req && (!cpu_req || w_starved))
            winner = OWN_DMA;
        else if (cpu_req)
            winner = OWN_CPU;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (!halt_sys) begin
            if (!dma_req)
                r_starve <= '0;
            else if (grant_event && winner == OWN_DMA)
                r_starve <= '0;
            else if (grant_event && winner == OWN_CPU && !w_starved)
                r_starve <= r_starve + SW'(1);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter: CPU-priority grant, fixed-latency access
// sequencing (IDLE -> ACCESS -> ACK) and halt_sys freeze support.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_sys,
    mem_arbiter_if.slave  bus,
    output owner_t        owner,
    output logic          busy
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_e    r_state,     w_state_nxt;
    owner_t        r_owner,     w_owner_nxt;
    logic [LW-1:0] r_lat,       w_lat_nxt;
    logic          r_we,        w_we_nxt;
    logic [AW-1:0] r_addr,      w_addr_nxt;
    logic [DW-1:0] r_wdata,     w_wdata_nxt;
    logic [DW-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DW-1:0] r_dma_rdata, w_dma_rdata_nxt;
    owner_t        w_winner;
    logic          w_grant;
    logic          w_lat_done;

    assign w_grant    = (r_state == ARB_IDLE) && !halt_sys && (bus.cpu_req || bus.dma_req);
    assign w_lat_done = (r_lat == LW'(MEM_LAT - 1));

    arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (bus.cpu_req),
        .dma_req     (bus.dma_req),
        .grant_event (w_grant),
        .halt_sys    (halt_sys),
        .winner      (w_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_NONE;
            r_lat       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_lat       <= w_lat_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_dma_rdata <= w_dma_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_lat_nxt       = r_lat;
        w_we_nxt        = r_we;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_dma_rdata_nxt = r_dma_rdata;
        // A halt freezes every piece of sequencing state in place.
        if (!halt_sys) begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        w_owner_nxt = w_winner;
                        w_lat_nxt   = '0;
                        w_state_nxt = ARB_ACCESS;
                        if (w_winner == OWN_DMA) begin
                            w_addr_nxt  = bus.dma_addr;
                            w_wdata_nxt = bus.dma_wdata;
                            w_we_nxt    = bus.dma_we;
                        end else begin
                            w_addr_nxt  = bus.cpu_addr;
                            w_wdata_nxt = bus.cpu_wdata;
                            w_we_nxt    = bus.cpu_we;
                        end
                    end
                end
                ARB_ACCESS: begin
                    w_lat_nxt = r_lat + LW'(1);
                    if (w_lat_done) begin
                        w_state_nxt = ARB_ACK;
                        if (!r_we && r_owner == OWN_CPU) w_cpu_rdata_nxt = bus.mem_rdata;
                        if (!r_we && r_owner == OWN_DMA) w_dma_rdata_nxt = bus.mem_rdata;
                    end
                end
                ARB_ACK: begin
                    w_state_nxt = ARB_IDLE;
                    w_owner_nxt = OWN_NONE;
                end
                default: begin
                    w_state_nxt = ARB_IDLE;
                    w_owner_nxt = OWN_NONE;
                end
            endcase
        end
    end

    // Write strobe only in the first ACCESS cycle so each transaction writes once.
    assign bus.mem_we    = (r_state == ARB_ACCESS) && (r_lat == '0) && r_we && !halt_sys;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_ack   = (r_state == ARB_ACK) && (r_owner == OWN_CPU) && !halt_sys;
    assign bus.dma_ack   = (r_state == ARB_ACK) && (r_owner == OWN_DMA) && !halt_sys;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    assign owner         = r_owner;
    assign busy          = (r_state != ARB_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover MEM_LAT=1/STARVE_MAX=4,
// STARVE_MAX=2 fairness, and MEM_LAT=3 with a halt_sys freeze.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA, rstB, rstC;
    logic haltA, haltB, haltC;
    owner_t ownA, ownB, ownC;
    logic busyA, busyB, busyC;

    int ntests = 0;
    int nfail  = 0;

    mem_arbiter_if #(.AW(16), .DW(16)) ifa ();
    mem_arbiter_if #(.AW(16), .DW(16)) ifb ();
    mem_arbiter_if #(.AW(16), .DW(16)) ifc ();

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) ua (
        .clk(clk), .rst(rstA), .halt_sys(haltA), .bus(ifa), .owner(ownA), .busy(busyA));
    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(2)) ub (
        .clk(clk), .rst(rstB), .halt_sys(haltB), .bus(ifb), .owner(ownB), .busy(busyB));
    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(4)) uc (
        .clk(clk), .rst(rstC), .halt_sys(haltC), .bus(ifc), .owner(ownC), .busy(busyC));

    // Memory for instance A: 0x0010 is preloaded with 0xBEEF.
    logic [15:0] memA [0:255];
    always @(posedge clk) if (ifa.mem_we) memA[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
    assign ifa.mem_rdata = (ifa.mem_addr == 16'h0010) ? 16'hBEEF : memA[ifa.mem_addr[7:0]];
    assign ifb.mem_rdata = ifb.mem_addr ^ 16'h5A5A;
    assign ifc.mem_rdata = ifc.mem_addr ^ 16'h5A5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [17:0] cpuv, dmav;
    logic [9:0]  ackv, wev;
    logic        addr_ok;

    initial begin
        rstA = 0; rstB = 0; rstC = 0;
        haltA = 0; haltB = 0; haltC = 0;
        ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = 0; ifa.cpu_wdata = 0;
        ifa.dma_req = 0; ifa.dma_we = 0; ifa.dma_addr = 0; ifa.dma_wdata = 0;
        ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = 0; ifb.cpu_wdata = 0;
        ifb.dma_req = 0; ifb.dma_we = 0; ifb.dma_addr = 0; ifb.dma_wdata = 0;
        ifc.cpu_req = 0; ifc.cpu_we = 0; ifc.cpu_addr = 0; ifc.cpu_wdata = 0;
        ifc.dma_req = 0; ifc.dma_we = 0; ifc.dma_addr = 0; ifc.dma_wdata = 0;
        tick(); tick();
        mid();
        chk("rst_owner", 32'(ownA), 32'(OWN_NONE));
        chk("rst_busy", 32'(busyA), 0);
        chk("rst_mem_we", 32'(ifa.mem_we), 0);
        chk("rst_acks", {ifa.cpu_ack, ifa.dma_ack}, 0);
        chk("rst_mem_addr", 32'(ifa.mem_addr), 0);
        chk("rst_rdata", {ifa.cpu_rdata, ifa.dma_rdata}, 0);
        tick();
        rstA = 1; rstB = 1; rstC = 1;
        tick();

        // CPU read of 0x0010 (cycle 0 = first request cycle)
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 16'h0010;
        mid(); chk("t1_stall_c0", 32'(ifa.cpu_stall), 1);
        tick(); mid();
        chk("t1_stall_c1", 32'(ifa.cpu_stall), 1);
        chk("t1_owner_c1", 32'(ownA), 32'(OWN_CPU));
        chk("t1_busy_c1", 32'(busyA), 1);
        tick(); mid();
        chk("t1_ack_c2", 32'(ifa.cpu_ack), 1);
        chk("t1_rdata_c2", 32'(ifa.cpu_rdata), 32'h0000BEEF);
        chk("t1_owner_c2", 32'(ownA), 32'(OWN_CPU));
        chk("t1_stall_c2", 32'(ifa.cpu_stall), 0);
        tick();
        ifa.cpu_req = 0;
        mid();
        chk("t1_ack_c3", 32'(ifa.cpu_ack), 0);
        chk("t1_owner_c3", 32'(ownA), 32'(OWN_NONE));
        tick();

        // Simultaneous: DMA write 0x0020<-0x1234, CPU read 0x0030
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 16'h0030;
        ifa.dma_req = 1; ifa.dma_we = 1; ifa.dma_addr = 16'h0020; ifa.dma_wdata = 16'h1234;
        mid(); chk("t2_we_c0", 32'(ifa.mem_we), 0);
        tick(); mid(); chk("t2_we_c1", 32'(ifa.mem_we), 0);
        tick(); mid();
        chk("t2_cpu_ack_c2", 32'(ifa.cpu_ack), 1);
        chk("t2_dma_ack_c2", 32'(ifa.dma_ack), 0);
        tick();
        ifa.cpu_req = 0;
        mid(); chk("t2_we_c3", 32'(ifa.mem_we), 0);
        tick(); mid();
        chk("t2_we_c4", 32'(ifa.mem_we), 1);
        chk("t2_addr_c4", 32'(ifa.mem_addr), 32'h0020);
        chk("t2_wdata_c4", 32'(ifa.mem_wdata), 32'h1234);
        chk("t2_owner_c4", 32'(ownA), 32'(OWN_DMA));
        tick(); mid();
        chk("t2_dma_ack_c5", 32'(ifa.dma_ack), 1);
        chk("t2_we_c5", 32'(ifa.mem_we), 0);
        tick();
        ifa.dma_req = 0;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 16'h0020;
        tick(); tick(); mid();
        chk("t2_rb_ack", 32'(ifa.cpu_ack), 1);
        chk("t2_rb_rdata", 32'(ifa.cpu_rdata), 32'h1234);
        tick();
        ifa.cpu_req = 0;
        tick();

        // CPU write held past ack: two back-to-back transactions
        ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.cpu_addr = 16'h0050; ifa.cpu_wdata = 16'h0A0A;
        ackv = '0; wev = '0;
        for (int c = 0; c < 6; c++) begin
            mid();
            ackv[c] = ifa.cpu_ack;
            wev[c]  = ifa.mem_we;
            tick();
        end
        ifa.cpu_req = 0; ifa.cpu_we = 0;
        chk("t6_we_pattern", 32'(wev[5:0]), 32'b010010);
        chk("t6_ack_pattern", 32'(ackv[5:0]), 32'b100100);
        tick();

        // Reset in the first ACCESS cycle of a DMA write
        ifa.dma_req = 1; ifa.dma_we = 1; ifa.dma_addr = 16'h0040; ifa.dma_wdata = 16'h5555;
        tick();
        rstA = 0; ifa.dma_req = 0;
        #1;
        chk("t5_rst_we", 32'(ifa.mem_we), 0);
        chk("t5_rst_owner", 32'(ownA), 32'(OWN_NONE));
        chk("t5_rst_busy", 32'(busyA), 0);
        tick();
        rstA = 1;
        ackv = '0;
        for (int c = 0; c < 4; c++) begin
            mid(); ackv[c] = ifa.dma_ack; tick();
        end
        chk("t5_no_ack", 32'(ackv[3:0]), 0);
        ifa.dma_req = 1;
        tick(); tick(); mid();
        chk("t5_reissue_ack", 32'(ifa.dma_ack), 1);
        tick();
        ifa.dma_req = 0; ifa.dma_we = 0;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 16'h0040;
        tick(); tick(); mid();
        chk("t5_rb_rdata", 32'(ifa.cpu_rdata), 32'h5555);
        tick();
        ifa.cpu_req = 0;
        tick();

        // STARVE_MAX=2 fairness with both requests held
        ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_addr = 16'h0100;
        ifb.dma_req = 1; ifb.dma_we = 0; ifb.dma_addr = 16'h0200;
        cpuv = '0; dmav = '0;
        for (int c = 0; c < 18; c++) begin
            mid();
            cpuv[c] = ifb.cpu_ack;
            dmav[c] = ifb.dma_ack;
            tick();
        end
        ifb.cpu_req = 0; ifb.dma_req = 0;
        chk("t3_cpu_acks", 32'(cpuv), 32'h04824);
        chk("t3_dma_acks", 32'(dmav), 32'h20100);
        chk("t3_cpu_rdata", 32'(ifb.cpu_rdata), 32'h5B5A);
        chk("t3_dma_rdata", 32'(ifb.dma_rdata), 32'h585A);
        tick();

        // MEM_LAT=3 CPU read with halt_sys high in cycles 2..4
        ifc.cpu_req = 1; ifc.cpu_we = 0; ifc.cpu_addr = 16'h0033;
        ackv = '0; wev = '0; addr_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            haltC = (c >= 2 && c <= 4);
            if (c == 8) ifc.cpu_req = 0;
            mid();
            ackv[c] = ifc.cpu_ack;
            wev[c]  = ifc.mem_we;
            if (c >= 1 && c <= 7 && ifc.mem_addr !== 16'h0033) addr_ok = 1'b0;
            tick();
        end
        haltC = 0;
        chk("t4_ack_cycle", 32'(ackv), 32'h080);
        chk("t4_no_we", 32'(wev), 0);
        chk("t4_addr_stable", 32'(addr_ok), 1);
        chk("t4_rdata", 32'(ifc.cpu_rdata), 32'h5A69);
        chk("t4_idle_after", 32'(busyC), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
